// File: rtl/jtdsp16_wsel.sv
// DSP16 register write dispatcher: in-order queue of register writes, each
// issued as a one-cycle strobe on a shared 16-bit bus once its target is idle.
module jtdsp16_wsel #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [2:0]  wsel,
  input  logic [15:0] wdata,
  input  logic        busy_yaau,
  input  logic        busy_xaau,
  input  logic        busy_dau,
  input  logic        busy_if,
  output logic        we_yaau,
  output logic        we_xaau,
  output logic        we_dau,
  output logic        we_if,
  output logic [15:0] wbus,
  output logic [3:0]  pending
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]    tgt_q [DEPTH];
  logic [1:0]    tgt_d [DEPTH];
  logic [15:0]   dat_q [DEPTH];
  logic [15:0]   dat_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    we_q, we_d;
  logic [15:0]   wbus_q, wbus_d;

  logic [3:0]    busy;
  logic [1:0]    head_tgt;
  logic          push, pop;
  logic [PW-1:0] off;
  logic [3:0]    pend_v;

  always_comb begin
    busy     = {busy_if, busy_dau, busy_xaau, busy_yaau};
    head_tgt = tgt_q[rd_q];
    w_ready  = !rst && (cnt_q < DEPTH_C);
    push     = cen && w_valid && w_ready;
    // Only the head's own busy matters; younger entries wait behind it.
    pop      = cen && (cnt_q != '0) && !busy[head_tgt];

    tgt_d  = tgt_q;
    dat_d  = dat_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    we_d   = we_q;
    wbus_d = wbus_q;

    if (push) begin
      tgt_d[wr_q] = (wsel > 3'd2) ? 2'd3 : wsel[1:0];
      dat_d[wr_q] = wdata;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (cen) begin
      we_d = pop ? (4'b0001 << head_tgt) : 4'b0000;
      if (pop) wbus_d = dat_q[rd_q];
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pend_v = we_q;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if ({1'b0, off} < cnt_q) pend_v[tgt_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i] <= '0;
        dat_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      we_q   <= '0;
      wbus_q <= '0;
    end else begin
      tgt_q  <= tgt_d;
      dat_q  <= dat_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      wbus_q <= wbus_d;
    end
  end

  assign we_yaau = we_q[0];
  assign we_xaau = we_q[1];
  assign we_dau  = we_q[2];
  assign we_if   = we_q[3];
  assign wbus    = wbus_q;
  assign pending = pend_v;

endmodule

// File: tb/tb_jtdsp16_wsel.sv
// Bench for jtdsp16_wsel: scoreboard of accepted writes checked against each
// fresh strobe, plus per-scenario timing checks at DEPTH=2 and DEPTH=4.
module tb_jtdsp16_wsel;

  logic        clk = 0;
  logic        rst, cen, w_valid;
  logic [2:0]  wsel;
  logic [15:0] wdata;
  logic        busy_yaau, busy_xaau, busy_dau, busy_if;
  logic        w_ready, we_yaau, we_xaau, we_dau, we_if;
  logic [15:0] wbus;
  logic [3:0]  pending;
  logic [3:0]  we_vec;

  logic        v4, by4, rdy4;
  logic [2:0]  ws4;
  logic [15:0] wd4, wbus4;
  logic        we4_y, we4_x, we4_d, we4_i;
  logic [3:0]  pend4, we4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic [1:0] tgt; logic [15:0] data;} exp_t;
  exp_t sb[$];
  bit   last_cen = 0;
  bit   last_rst = 1;

  always #5 clk = ~clk;

  jtdsp16_wsel #(.DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .w_valid(w_valid), .w_ready(w_ready),
    .wsel(wsel), .wdata(wdata),
    .busy_yaau(busy_yaau), .busy_xaau(busy_xaau), .busy_dau(busy_dau), .busy_if(busy_if),
    .we_yaau(we_yaau), .we_xaau(we_xaau), .we_dau(we_dau), .we_if(we_if),
    .wbus(wbus), .pending(pending)
  );

  jtdsp16_wsel #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .cen(cen), .w_valid(v4), .w_ready(rdy4),
    .wsel(ws4), .wdata(wd4),
    .busy_yaau(by4), .busy_xaau(1'b0), .busy_dau(1'b0), .busy_if(1'b0),
    .we_yaau(we4_y), .we_xaau(we4_x), .we_dau(we4_d), .we_if(we4_i),
    .wbus(wbus4), .pending(pend4)
  );

  assign we_vec = {we_if, we_dau, we_xaau, we_yaau};
  assign we4    = {we4_i, we4_d, we4_x, we4_y};

  function automatic logic [1:0] tgt_of(input logic [2:0] s);
    return (s > 3'd2) ? 2'd3 : s[1:0];
  endfunction

  // Pre-edge values are visible here, so this records what the edge accepts.
  always @(posedge clk) begin
    last_cen = cen;
    last_rst = rst;
    if (rst) sb.delete();
    else if (cen && w_valid && w_ready) sb.push_back({tgt_of(wsel), wdata});
  end

  // A strobe is new only if the preceding edge had cen=1.
  always @(negedge clk) begin
    exp_t e;
    if (!last_rst && last_cen && we_vec != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_stale: strobe we=%b wbus=%h, required no strobe", we_vec, wbus);
      end else begin
        e = sb.pop_front();
        if (we_vec !== (4'b0001 << e.tgt) || wbus !== e.data) begin
          errors++;
          $display("FAIL sb_strobe: we=%b wbus=%h, required we=%b wbus=%h",
                   we_vec, wbus, 4'b0001 << e.tgt, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1; cen = 1; w_valid = 0; wsel = 0; wdata = 0;
    busy_yaau = 0; busy_xaau = 0; busy_dau = 0; busy_if = 0;
    v4 = 0; ws4 = 0; wd4 = 0; by4 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", w_ready); end
    checks++;
    if (we_vec !== 4'b0 || wbus !== 16'h0 || pending !== 4'b0) begin
      errors++; $display("FAIL reset_outs: we=%b wbus=%h pend=%b, required 0", we_vec, wbus, pending);
    end
    rst = 0; #1;
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", w_ready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    checks++;
    if (pending !== 4'b0) begin errors++; $display("FAIL single_pend0: got %b, required 0000", pending); end
    w_valid = 1; wsel = 3'd2; wdata = 16'h1234;
    @(negedge clk);
    w_valid = 0;
    checks++;
    if (we_vec !== 4'b0 || pending !== 4'b0100) begin
      errors++; $display("FAIL single_queued: we=%b pend=%b, required we=0000 pend=0100", we_vec, pending);
    end
    @(negedge clk);
    checks++;
    if (we_vec !== 4'b0100 || wbus !== 16'h1234 || pending !== 4'b0100) begin
      errors++; $display("FAIL single_strobe: we=%b wbus=%h pend=%b, required 0100/1234/0100", we_vec, wbus, pending);
    end
    @(negedge clk);
    checks++;
    if (we_vec !== 4'b0 || pending !== 4'b0 || wbus !== 16'h1234) begin
      errors++; $display("FAIL single_after: we=%b wbus=%h pend=%b, required 0000/1234/0000", we_vec, wbus, pending);
    end
  endtask

  task automatic test_stream();
    logic [2:0] ws [4];
    logic [3:0] ewe [4];
    ws  = '{3'd0, 3'd1, 3'd5, 3'd2};
    ewe = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        w_valid = 1; wsel = ws[k]; wdata = 16'hA000 + 16'(k);
        checks++;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d: got %b, required 1", k, w_ready); end
      end else w_valid = 0;
      if (k >= 2) begin
        checks++;
        if (we_vec !== ewe[k-2] || wbus !== 16'hA000 + 16'(k-2)) begin
          errors++; $display("FAIL stream_strobe k=%0d: we=%b wbus=%h, required %b/%h", k, we_vec, wbus, ewe[k-2], 16'hA000 + 16'(k-2));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (we_vec !== 4'b0 || sb.size() != 0) begin
      errors++; $display("FAIL stream_drain: we=%b sb=%0d, required 0000/0", we_vec, sb.size());
    end
  endtask

  task automatic test_busy();
    busy_dau = 1;
    w_valid = 1; wsel = 3'd2; wdata = 16'h0055;
    @(negedge clk);
    wsel = 3'd0; wdata = 16'h0066;
    @(negedge clk);
    w_valid = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (w_ready !== 1'b0 || pending !== 4'b0101 || we_vec !== 4'b0) begin
        errors++; $display("FAIL busy_full k=%0d: rdy=%b pend=%b we=%b, required 0/0101/0000", k, w_ready, pending, we_vec);
      end
      @(negedge clk);
    end
    busy_dau = 0;
    @(negedge clk);
    checks++;
    if (we_vec !== 4'b0100 || wbus !== 16'h0055 || w_ready !== 1'b1) begin
      errors++; $display("FAIL busy_release_dau: we=%b wbus=%h rdy=%b, required 0100/0055/1", we_vec, wbus, w_ready);
    end
    @(negedge clk);
    checks++;
    if (we_vec !== 4'b0001 || wbus !== 16'h0066) begin
      errors++; $display("FAIL busy_release_yaau: we=%b wbus=%h, required 0001/0066", we_vec, wbus);
    end
    @(negedge clk);
    checks++;
    if (we_vec !== 4'b0 || pending !== 4'b0) begin
      errors++; $display("FAIL busy_done: we=%b pend=%b, required 0000/0000", we_vec, pending);
    end
  endtask

  task automatic test_cen();
    logic [2:0]  ws [3];
    logic [23:0] snap, cur;
    bit prev_cen;
    int idx;
    ws = '{3'd1, 3'd2, 3'd3};
    prev_cen = 1; idx = 0; snap = '0;
    for (int c = 0; c < 12; c++) begin
      cur = {we_vec, wbus, pending};
      if (!prev_cen) begin
        checks++;
        if (cur !== snap) begin errors++; $display("FAIL cen_freeze c=%0d: got %h, required %h", c, cur, snap); end
      end
      snap = cur;
      cen = (c % 2 == 0);
      if (idx < 3) begin
        w_valid = 1; wsel = ws[idx]; wdata = 16'hB000 + 16'(idx);
        checks++;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL cen_ready c=%0d: got %b, required 1", c, w_ready); end
      end else w_valid = 0;
      prev_cen = cen;
      if (cen && idx < 3) idx++;
      @(negedge clk);
    end
    cen = 1; w_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0 || we_vec !== 4'b0) begin
      errors++; $display("FAIL cen_drain: sb=%0d we=%b, required 0/0000", sb.size(), we_vec);
    end
  endtask

  task automatic test_reset_mid();
    busy_if = 1;
    w_valid = 1; wsel = 3'd4; wdata = 16'hC000;
    @(negedge clk);
    wsel = 3'd7; wdata = 16'hC001;
    @(negedge clk);
    w_valid = 0;
    checks++;
    if (w_ready !== 1'b0 || pending !== 4'b1000) begin
      errors++; $display("FAIL rstmid_full: rdy=%b pend=%b, required 0/1000", w_ready, pending);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (w_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b, required 0", w_ready); end
    rst = 0; #1;
    checks++;
    if (we_vec !== 4'b0 || wbus !== 16'h0 || pending !== 4'b0 || w_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_cleared: we=%b wbus=%h pend=%b rdy=%b, required 0/0/0/1", we_vec, wbus, pending, w_ready);
    end
    busy_if = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (we_vec !== 4'b0) begin errors++; $display("FAIL rstmid_stale k=%0d: we=%b, required 0000", k, we_vec); end
    end
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        w_valid = 1; wsel = 3'd1; wdata = 16'hD000 + 16'(k);
        checks++;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL pp_ready k=%0d: got %b, required 1", k, w_ready); end
      end else w_valid = 0;
      if (k >= 1) begin
        checks++;
        if (pending !== 4'b0010) begin errors++; $display("FAIL pp_pend k=%0d: got %b, required 0010", k, pending); end
      end
      if (k >= 2) begin
        checks++;
        if (we_vec !== 4'b0010 || wbus !== 16'hD000 + 16'(k-2)) begin
          errors++; $display("FAIL pp_strobe k=%0d: we=%b wbus=%h, required 0010/%h", k, we_vec, wbus, 16'hD000 + 16'(k-2));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (we_vec !== 4'b0 || sb.size() != 0) begin
      errors++; $display("FAIL pp_drain: we=%b sb=%0d, required 0000/0", we_vec, sb.size());
    end
  endtask

  task automatic test_d4();
    for (int k = 0; k < 9; k++) begin
      if (k < 7) begin
        v4 = 1; ws4 = 3'd1; wd4 = 16'hE000 + 16'(k);
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL d4_pp_ready k=%0d: got %b, required 1", k, rdy4); end
      end else v4 = 0;
      if (k >= 2) begin
        checks++;
        if (we4 !== 4'b0010 || wbus4 !== 16'hE000 + 16'(k-2)) begin
          errors++; $display("FAIL d4_pp_strobe k=%0d: we=%b wbus=%h, required 0010/%h", k, we4, wbus4, 16'hE000 + 16'(k-2));
        end
      end
      @(negedge clk);
    end
    by4 = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdy4 !== 1'b1) begin errors++; $display("FAIL d4_fill_ready k=%0d: got %b, required 1", k, rdy4); end
      v4 = 1; ws4 = 3'd0; wd4 = 16'hF000 + 16'(k);
      @(negedge clk);
    end
    v4 = 0;
    checks++;
    if (rdy4 !== 1'b0 || pend4 !== 4'b0001 || we4 !== 4'b0) begin
      errors++; $display("FAIL d4_full: rdy=%b pend=%b we=%b, required 0/0001/0000", rdy4, pend4, we4);
    end
    by4 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (we4 !== 4'b0001 || wbus4 !== 16'hF000 + 16'(k) || rdy4 !== 1'b1) begin
        errors++; $display("FAIL d4_drain k=%0d: we=%b wbus=%h rdy=%b, required 0001/%h/1", k, we4, wbus4, rdy4, 16'hF000 + 16'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (we4 !== 4'b0 || pend4 !== 4'b0) begin
      errors++; $display("FAIL d4_idle: we=%b pend=%b, required 0000/0000", we4, pend4);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_busy();
    test_cen();
    test_reset_mid();
    test_push_pop();
    test_d4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdsp16_wsel.md
# jtdsp16_wsel

Register write dispatcher for the DSP16 core. It takes register-write requests from the instruction decoder and queues them in order. Each write goes to its target unit (YAAU, XAAU, DAU or interface block) as a single-cycle write strobe on a shared 16-bit write bus. A write is held while its target reports busy. This is the write-side counterpart of the register read selector and uses the same destination encoding.

## Interface
- DEPTH, 2, queue depth in entries; legal values 2 or 4.

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cen  in  1  clock enable; all state advances only on edges with cen=1
- w_valid  in  1  write request present
- w_ready  out  1  queue can accept a request
- wsel  in  3  destination: 0=YAAU, 1=XAAU, 2=DAU, 3..7=IF
- wdata  in  16  write data
- busy_yaau, busy_xaau, busy_dau, busy_if  in  1 each  target cannot accept a write this cycle
- we_yaau, we_xaau, we_dau, we_if  out  1 each  registered write strobe
- wbus  out  16  registered write data, valid while any we_* is high
- pending  out  4  {if,dau,xaau,yaau}: a write to that unit is queued or strobing

## Operation
- Queue:
  - circular buffer of DEPTH entries {tgt[1:0], data[15:0]}
  - tgt = 0, 1 or 2 for wsel 0, 1, 2; tgt = 3 for wsel 3..7
  - read and write pointers of log2(DEPTH) bits wrap modulo DEPTH
  - count of log2(DEPTH)+1 bits
- Accept:
  - a request is accepted on a cen edge with w_valid & w_ready
  - w_ready = !rst & (count < DEPTH); it depends only on registered state, never on w_valid
- Issue, on each cen edge:
  - condition: count>0 and busy of the head's target is 0
  - head is popped
  - the matching we_* is set to 1, all other we_* are set to 0, wbus is loaded with the head data
- Otherwise, on a cen edge, all we_* are cleared.
  - wbus keeps its last value; it is not zeroed.
- Ordering:
  - strictly in order
  - a busy head blocks younger entries even when their targets are idle
- Simultaneous push and pop on one edge: both happen and count is unchanged.
  - When full, w_ready=0, so no push happens on the edge of a pop.
- pending[i]: set if any valid queue entry has tgt=i, or we_i is currently high. It is combinational from registered state.
- Busy inputs are sampled on the issue edge only. A busy rising after a strobe has issued does not cancel the strobe.
- cen=0: queue, pointers, we_* and wbus all hold. Targets must qualify we_* with cen.
- Reset, including mid-operation: queue emptied, pointers and count set to 0, we_*=0, wbus=0, pending=0, w_ready=0 while rst=1. Queued writes are discarded.

## Timing
- With an empty queue and an idle target, a request accepted at cen edge N produces a strobe that is high from edge N+1 to edge N+2.
- Steady state (target idle, w_valid held high): one write per cen edge. Minimum queue occupancy is 1.
- Busy high at edge K on the head's target: no strobe at K. The head issues at the first cen edge where its busy is 0.
- Back-to-back writes to the same target give consecutive strobe cycles with new wbus data each cycle.
- A full queue drops w_ready in the cycle after the filling edge. It rises in the cycle after the first pop.
- wbus and we_* change only on cen edges; no combinational path from any input to them.

## Test plan
- Reset, then write wsel=2, wdata=16'h1234 with busy low:
  - we_dau=1 and wbus=16'h1234 for exactly one cen cycle, one edge after acceptance
  - pending[2]=1 from acceptance until the strobe drops
- Stream wsel 0,1,5,2 with data 16'hA000..A003, all idle:
  - strobes in order we_yaau, we_xaau, we_if, we_dau on consecutive cycles with the matching data
  - w_ready stays high throughout
- Hold busy_dau=1, send wsel=2 (16'h0055) then wsel=0 (16'h0066):
  - no strobes
  - queue fills (DEPTH=2), w_ready=0, pending=4'b0101
  - drop busy_dau: we_dau/16'h0055 on the next edge, we_yaau/16'h0066 on the following edge
- Toggle cen 1-0-1 during a stream:
  - all outputs freeze while cen=0
  - the strobe sequence and data are identical to the cen=1 run, only stretched
- Fill the queue with busy_if=1, then assert rst for one edge mid-operation:
  - after the reset edge, count=0, we_*=0, wbus=0, pending=0, and no stale strobe appears after busy_if drops
- Push and pop on the same edge at count=1:
  - count stays 1 and data order is preserved across the pointer wrap at DEPTH=2 and at DEPTH=4
